// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions for the EX-stage divider sequencer.
// Contains the operand width, the divider latency and the FSM state encoding.
package cpu_defs;

  localparam int W          = 32;
  localparam int DIV_CYCLES = 34;
  localparam int CNT_W      = 6;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DONE  = 2'd2,
    DRAIN = 2'd3
  } div_state_t;

endpackage

// File: rtl/div_hilo_ctrl.sv
// EX-stage sequencer for the iterative divider: latches operands, drives the
// divider start window, stalls the pipeline and owns the HI/LO registers.
//
//  state | meaning
//  IDLE  | no divide in flight; accepts DIV/DIVU or MTHI/MTLO
//  RUN   | divider enabled, pipeline stalled, result will retire
//  DONE  | one-cycle retire; HI/LO written unless flushed
//  DRAIN | flushed divide still in flight; result is discarded
import cpu_defs::*;

module div_hilo_ctrl (
  input  logic           clk,
  input  logic           reset,
  input  logic           ex_div_req,
  input  logic           ex_div_sign,
  input  logic [W-1:0]   ex_rs,
  input  logic [W-1:0]   ex_rt,
  input  logic           ex_flush,
  input  logic           ex_mthi,
  input  logic           ex_mtlo,
  input  logic [W-1:0]   ex_wdata,
  output logic           div_start,
  output logic           div_op,
  output logic [W-1:0]   div_dividend,
  output logic [W-1:0]   div_divisor,
  input  logic [2*W-1:0] div_result,
  input  logic           div_end,
  output logic           stall_req,
  output logic           busy,
  output logic [W-1:0]   hi_out,
  output logic [W-1:0]   lo_out
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES);

  div_state_t       state;
  logic [CNT_W-1:0] cnt;
  logic             cnt_last;

  assign cnt_last = (cnt == CNT_LAST);

  // Stall is combinational so the accepting IDLE cycle already freezes IF..EX.
  always_comb begin
    stall_req = 1'b0;
    if (reset) begin
      unique case (state)
        IDLE:    stall_req = ex_div_req && !ex_flush;
        RUN:     stall_req = 1'b1;
        DONE:    stall_req = 1'b0;
        DRAIN:   stall_req = ex_div_req;
        default: stall_req = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cnt          <= '0;
      div_start    <= 1'b0;
      div_op       <= 1'b0;
      div_dividend <= '0;
      div_divisor  <= '0;
      busy         <= 1'b0;
      hi_out       <= '0;
      lo_out       <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ex_div_req && !ex_flush) begin
            div_dividend <= ex_rs;
            div_divisor  <= ex_rt;
            div_op       <= ex_div_sign;
            cnt          <= '0;
            div_start    <= 1'b1;
            busy         <= 1'b1;
            state        <= RUN;
          end else if (!ex_div_req && !ex_flush) begin
            if (ex_mthi) hi_out <= ex_wdata;
            if (ex_mtlo) lo_out <= ex_wdata;
          end
        end
        RUN: begin
          if (!cnt_last) cnt <= cnt + 1'b1;
          if (cnt_last) begin
            div_start <= 1'b0;
            // A flush on the final run cycle has nothing left to drain.
            if (ex_flush) begin
              busy  <= 1'b0;
              state <= IDLE;
            end else begin
              state <= DONE;
            end
          end else if (ex_flush) begin
            state <= DRAIN;
          end
        end
        DONE: begin
          if (!ex_flush) begin
            hi_out <= div_result[2*W-1:W];
            lo_out <= div_result[W-1:0];
          end
          busy  <= 1'b0;
          state <= IDLE;
        end
        DRAIN: begin
          if (!cnt_last) cnt <= cnt + 1'b1;
          if (cnt_last) begin
            div_start <= 1'b0;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          div_start <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  // The divider must have finished by the time the result retires.
  always_ff @(posedge clk) begin
    if (reset && state == DONE) assert (div_end);
  end

endmodule
